// File: rtl/noc_port_mux_pkg.sv
// rtl/noc_port_mux_pkg.sv - shared router constants, port indices and select type
package noc_port_mux_pkg;

    localparam int DATAW = 8;
    localparam int VCHW  = 1;
    localparam int NPORT = 5;

    // Input port indices; directional aliases follow the usual router layout
    localparam int PORT_0 = 0;
    localparam int PORT_1 = 1;
    localparam int PORT_2 = 2;
    localparam int PORT_3 = 3;
    localparam int PORT_4 = 4;

    localparam int PORT_LOCAL = PORT_0;
    localparam int PORT_N     = PORT_1;
    localparam int PORT_E     = PORT_2;
    localparam int PORT_S     = PORT_3;
    localparam int PORT_W     = PORT_4;

    typedef logic [NPORT-1:0] sel_t;

endpackage

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - classifies a select vector as idle, one-hot or multi-hot
module onehot_check
    import noc_port_mux_pkg::*;
(
    input  logic [NPORT-1:0] sel,
    output logic             is_zero,
    output logic             is_multi
);

    logic [NPORT-1:0] low_cleared;

    // Clearing the lowest set bit leaves something only when two or more bits were set
    always_comb begin
        low_cleared = sel & (sel - NPORT'(1));
        is_zero     = (sel == '0);
        is_multi    = (low_cleared != '0);
    end

endmodule

// File: rtl/noc_port_mux.sv
// rtl/noc_port_mux.sv - registered 5:1 flit selector for one router output port
module noc_port_mux
    import noc_port_mux_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [DATAW-1:0] idata_0,
    input  logic [DATAW-1:0] idata_1,
    input  logic [DATAW-1:0] idata_2,
    input  logic [DATAW-1:0] idata_3,
    input  logic [DATAW-1:0] idata_4,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic             ivalid_2,
    input  logic             ivalid_3,
    input  logic             ivalid_4,
    input  logic [VCHW-1:0]  ivch_0,
    input  logic [VCHW-1:0]  ivch_1,
    input  logic [VCHW-1:0]  ivch_2,
    input  logic [VCHW-1:0]  ivch_3,
    input  logic [VCHW-1:0]  ivch_4,
    input  logic [NPORT-1:0] sel,
    output logic [DATAW-1:0] odata,
    output logic             ovalid,
    output logic [VCHW-1:0]  ovch,
    output logic             sel_err
);

    logic             sel_zero;
    logic             sel_multi;

    logic [DATAW-1:0] mux_data;
    logic             mux_valid;
    logic [VCHW-1:0]  mux_vch;

    logic [DATAW-1:0] odata_d,   odata_q;
    logic             ovalid_d,  ovalid_q;
    logic [VCHW-1:0]  ovch_d,    ovch_q;
    logic             sel_err_d, sel_err_q;

    onehot_check u_onehot_check (
        .sel      (sel),
        .is_zero  (sel_zero),
        .is_multi (sel_multi)
    );

    // AND-OR selection; only meaningful when sel is one-hot, masked below otherwise
    always_comb begin
        mux_data  = ({DATAW{sel[PORT_0]}} & idata_0)
                  | ({DATAW{sel[PORT_1]}} & idata_1)
                  | ({DATAW{sel[PORT_2]}} & idata_2)
                  | ({DATAW{sel[PORT_3]}} & idata_3)
                  | ({DATAW{sel[PORT_4]}} & idata_4);
        mux_valid = (sel[PORT_0] & ivalid_0)
                  | (sel[PORT_1] & ivalid_1)
                  | (sel[PORT_2] & ivalid_2)
                  | (sel[PORT_3] & ivalid_3)
                  | (sel[PORT_4] & ivalid_4);
        mux_vch   = ({VCHW{sel[PORT_0]}} & ivch_0)
                  | ({VCHW{sel[PORT_1]}} & ivch_1)
                  | ({VCHW{sel[PORT_2]}} & ivch_2)
                  | ({VCHW{sel[PORT_3]}} & ivch_3)
                  | ({VCHW{sel[PORT_4]}} & ivch_4);
    end

    // Idle or illegal select drives a null flit; illegal select also raises the error flag
    always_comb begin
        odata_d   = '0;
        ovalid_d  = 1'b0;
        ovch_d    = '0;
        sel_err_d = sel_multi;
        if (!sel_zero && !sel_multi) begin
            odata_d  = mux_data;
            ovalid_d = mux_valid;
            ovch_d   = mux_vch;
        end
    end

    // Single output register stage; reset wins over any select
    always_ff @(posedge clk) begin
        if (rst) begin
            odata_q   <= '0;
            ovalid_q  <= 1'b0;
            ovch_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            odata_q   <= odata_d;
            ovalid_q  <= ovalid_d;
            ovch_q    <= ovch_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign odata   = odata_q;
    assign ovalid  = ovalid_q;
    assign ovch    = ovch_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_noc_port_mux.sv
// tb/tb_noc_port_mux.sv - scoreboard bench for the registered output-port selector
module tb_noc_port_mux;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       valid;
        logic       vch;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] id [5];
    logic       iv [5];
    logic       ic [5];
    logic [4:0] sel;
    logic [7:0] odata;
    logic       ovalid;
    logic       ovch;
    logic       sel_err;

    exp_t exp_q [$];
    int   n_checks;
    int   n_pass;

    noc_port_mux dut (
        .clk      (clk),
        .rst      (rst),
        .idata_0  (id[0]),
        .idata_1  (id[1]),
        .idata_2  (id[2]),
        .idata_3  (id[3]),
        .idata_4  (id[4]),
        .ivalid_0 (iv[0]),
        .ivalid_1 (iv[1]),
        .ivalid_2 (iv[2]),
        .ivalid_3 (iv[3]),
        .ivalid_4 (iv[4]),
        .ivch_0   (ic[0]),
        .ivch_1   (ic[1]),
        .ivch_2   (ic[2]),
        .ivch_3   (ic[3]),
        .ivch_4   (ic[4]),
        .sel      (sel),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch),
        .sel_err  (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_out(input string nm, input logic [7:0] d, input logic v,
                              input logic c, input logic e);
        exp_t x;
        x.name  = nm;
        x.data  = d;
        x.valid = v;
        x.vch   = c;
        x.err   = e;
        exp_q.push_back(x);
    endtask

    // Monitor: every edge whose stimulus was scored gets compared 1 time unit later
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_checks++;
                if (odata === x.data && ovalid === x.valid && ovch === x.vch && sel_err === x.err)
                    n_pass++;
                else
                    $display("FAIL %s: got data=%02h valid=%0b vch=%0b err=%0b, want data=%02h valid=%0b vch=%0b err=%0b",
                             x.name, odata, ovalid, ovch, sel_err, x.data, x.valid, x.vch, x.err);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        sel = 5'b00001;
        id[0] = 8'h10; id[1] = 8'h21; id[2] = 8'h32; id[3] = 8'h43; id[4] = 8'h54;
        for (int i = 0; i < 5; i++) iv[i] = 1'b1;
        ic[0] = 1'b1; ic[1] = 1'b0; ic[2] = 1'b1; ic[3] = 1'b0; ic[4] = 1'b1;

        @(negedge clk); rst = 1'b1; sel = 5'b00001; expect_out("reset_0", 8'h00, 0, 0, 0);
        @(negedge clk); rst = 1'b1;                 expect_out("reset_1", 8'h00, 0, 0, 0);

        @(negedge clk); rst = 1'b0; sel = 5'b00001; expect_out("port0", 8'h10, 1, 1, 0);
        @(negedge clk); sel = 5'b00010;             expect_out("port1", 8'h21, 1, 0, 0);
        @(negedge clk); sel = 5'b00100;             expect_out("port2", 8'h32, 1, 1, 0);
        @(negedge clk); sel = 5'b01000;             expect_out("port3", 8'h43, 1, 0, 0);
        @(negedge clk); sel = 5'b10000;             expect_out("port4", 8'h54, 1, 1, 0);

        @(negedge clk); sel = 5'b00000;             expect_out("idle", 8'h00, 0, 0, 0);
        @(negedge clk); sel = 5'b00101;             expect_out("multi_00101", 8'h00, 0, 0, 1);
        @(negedge clk); sel = 5'b00010;             expect_out("err_clears", 8'h21, 1, 0, 0);
        @(negedge clk); sel = 5'b11111;             expect_out("multi_all", 8'h00, 0, 0, 1);
        @(negedge clk); sel = 5'b00000;             expect_out("idle_after_err", 8'h00, 0, 0, 0);

        @(negedge clk); sel = 5'b01000; iv[3] = 1'b0; id[3] = 8'hAA;
        expect_out("invalid_passthru", 8'hAA, 0, 0, 0);
        @(negedge clk); id[0] = 8'hFF; iv[0] = 1'b0; ic[0] = 1'b0; id[4] = 8'h00;
        expect_out("unselected_ignored", 8'hAA, 0, 0, 0);

        @(negedge clk); sel = 5'b00100;             expect_out("latency_before", 8'h32, 1, 1, 0);
        @(negedge clk); id[2] = 8'h99;              expect_out("latency_after", 8'h99, 1, 1, 0);
        #1;
        n_checks++;
        if (odata === 8'h32) n_pass++;
        else $display("FAIL no_comb_path: got data=%02h, want data=32", odata);

        @(negedge clk); rst = 1'b1;                 expect_out("midstream_reset", 8'h00, 0, 0, 0);
        @(negedge clk); rst = 1'b0;                 expect_out("post_reset", 8'h99, 1, 1, 0);
        @(negedge clk); sel = 5'b10000; ic[4] = 1'b0; id[4] = 8'h54;
        expect_out("port4_vch0", 8'h54, 1, 0, 0);
        @(negedge clk); sel = 5'b11000;             expect_out("multi_adjacent", 8'h00, 0, 0, 1);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
